median_frame_ctrl: RTL

Frame-level sequencer for the serial 3×3 median filter (`MEDIAN`).
- Scans a WIDTH×HEIGHT 8-bit grayscale image in raster order, pixel by pixel.
- Reads each pixel's nine neighbours from a synchronous source RAM, clamping them to the image edges.
- Streams the nine neighbours into `MEDIAN` over its DI/DSI interface and waits for DSO.
- Writes the returned median to a destination RAM at the pixel's address.
- Sits between the image buffers and `MEDIAN`; replaces testbench-driven stimulus in the filter subsystem.

---
 rtl/median_ctrl_pkg.sv | 39 +++
 rtl/median_win_addr.sv | 35 +++
 rtl/median_frame_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/median_ctrl_pkg.sv
// Shared types and helpers for the median filter frame sequencer.
// Holds the FSM state enum, the tap count and the 3x3 tap offset map.
package median_ctrl_pkg;

  localparam int NTAPS = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic signed [1:0] i;
    logic signed [1:0] j;
  } tap_off_t;

  // k -> (row, col) offset: i = k/3 - 1, j = k%3 - 1
  function automatic tap_off_t tap_offset(input logic [3:0] k);
    tap_off_t   o;
    logic [3:0] r;
    if (k < 4'd3) begin
      o.i = -2'sd1;
      r   = k;
    end else if (k < 4'd6) begin
      o.i = 2'sd0;
      r   = k - 4'd3;
    end else begin
      o.i = 2'sd1;
      r   = k - 4'd6;
    end
    o.j = (r == 4'd0) ? -2'sd1 :
          (r == 4'd1) ?  2'sd0 : 2'sd1;
    return o;
  endfunction

endpackage

// File: rtl/median_win_addr.sv
// Edge-clamped 3x3 window address generator.
// Ports: x, y pixel; k tap index 0..8; addr = {ry, rx} of the clamped tap.
module median_win_addr
  import median_ctrl_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = XW + YW
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [3:0]    k,
  output logic [AW-1:0] addr
);

  tap_off_t              off;
  logic signed [XW+1:0]  sx;
  logic signed [YW+1:0]  sy;
  logic [XW-1:0]         rx;
  logic [YW-1:0]         ry;

  // Sums span [-1, size]; the sign bit flags underflow,
  // bit XW/YW alone flags the single overflow value.
  always_comb begin
    off = tap_offset(k);
    sx  = $signed({2'b00, x}) + {{XW{off.j[1]}}, off.j};
    sy  = $signed({2'b00, y}) + {{YW{off.i[1]}}, off.i};
    rx  = sx[XW+1] ? '0 : sx[XW] ? '1 : sx[XW-1:0];
    ry  = sy[YW+1] ? '0 : sy[YW] ? '1 : sy[YW-1:0];
    addr = {ry, rx};
  end

endmodule

// File: rtl/median_frame_ctrl.sv
// Raster-order frame sequencer feeding a serial 3x3 median unit.
// Ports: START/BUSY/DONE control, source RAM read, dest RAM write, DI/DSI/DO/DSO.
module median_frame_ctrl #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] RD_ADDR,
  input  logic [7:0]    RD_DATA,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [7:0]    WR_DATA,
  output logic [7:0]    DI,
  output logic          DSI,
  input  logic [7:0]    DO,
  input  logic          DSO
);
  import median_ctrl_pkg::*;

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  ctrl_state_t   st, st_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [3:0]    k, k_n;
  logic [AW-1:0] addr_n;
  logic          cap;

  // Fed with next-cycle counters so RD_ADDR is registered
  // yet already valid in the first FETCH cycle.
  median_win_addr #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_addr (
    .x   (x_n),
    .y   (y_n),
    .k   (k_n),
    .addr(addr_n)
  );

  always_comb begin
    st_n = st;
    x_n  = x;
    y_n  = y;
    k_n  = k;
    cap  = 1'b0;
    unique case (st)
      IDLE: begin
        if (START) begin
          st_n = FETCH;
          x_n  = '0;
          y_n  = '0;
          k_n  = '0;
        end
      end
      FETCH: begin
        if (k == 4'(NTAPS-1)) begin
          st_n = WAIT;
          k_n  = '0;
        end else begin
          k_n = k + 4'd1;
        end
      end
      WAIT: begin
        // DSO during the window's last tap belongs to no result
        if (DSO && !DSI) begin
          st_n = WRITE;
          cap  = 1'b1;
        end
      end
      WRITE: begin
        x_n = x + XW'(1);
        k_n = '0;
        if (x == '1) y_n = y + YW'(1);
        if (x == '1 && y == '1) st_n = median_ctrl_pkg::DONE;
        else                    st_n = FETCH;
      end
      median_ctrl_pkg::DONE: st_n = IDLE;
      default:               st_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st      <= IDLE;
      x       <= '0;
      y       <= '0;
      k       <= '0;
      DSI     <= 1'b0;
      RD_ADDR <= '0;
      WR_DATA <= '0;
    end else begin
      st  <= st_n;
      x   <= x_n;
      y   <= y_n;
      k   <= k_n;
      DSI <= (st == FETCH);
      if (st_n == FETCH) RD_ADDR <= addr_n;
      if (cap)           WR_DATA <= DO;
    end
  end

  assign BUSY    = (st == FETCH) || (st == WAIT) || (st == WRITE);
  assign DONE    = (st == median_ctrl_pkg::DONE);
  assign WR_EN   = (st == WRITE);
  assign WR_ADDR = {y, x};
  assign DI      = RD_DATA;

endmodule
